axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single AXI-stream S2MM input of the PS DMA between up to NSRC stream sources (stream_gen instances or other capture blocks).
- Grants one source per packet and holds the grant until that packet's tlast beat is accepted.
- Enforces a maximum packet length so that a source which never asserts tlast cannot stall the DMA.
- Exposes grant, packet-count and error status for the PS via GPIO/IRQ glue. Sits in the axi_aclk domain between the sources and the system block.

Parameters:
- NSRC, 4, number of source streams (2..8)
- DW, 32, tdata width in bits (multiple of 8)
- MAX_BEATS, 4096, maximum beats per output packet; beat MAX_BEATS is forced to tlast (>=2)

Ports:
- clk  in  1  axi_aclk
- areset  in  1  asynchronous, active-high reset
- en_mask  in  NSRC  per-source enable; sampled only at arbitration
- s_tdata  in  NSRC*DW  source data, source i at [i*DW +: DW]
- s_tkeep  in  NSRC*DW/8  source byte enables, same packing
- s_tlast  in  NSRC  source end of packet
- s_tvalid  in  NSRC  source valid
- s_tready  out  NSRC  source ready
- m_tdata  out  DW  to DMA stream_tdata
- m_tkeep  out  DW/8  to DMA stream_tkeep
- m_tlast  out  1  to DMA stream_tlast
- m_tvalid  out  1  to DMA stream_tvalid
- m_tready  in  1  from DMA stream_tready
- grant  out  NSRC  one-hot current owner; 0 when idle
- busy  out  1  high while in GRANT state
- pkt_count  out  32  output packets completed since reset; wraps 2^32-1 -> 0
- trunc_err  out  NSRC  sticky per source: packet from that source was truncated at MAX_BEATS
- err_clear  in  1  single-cycle pulse; clears all trunc_err bits

Behaviour:
- Reset, asynchronous and immediate, including mid-packet. Values on reset:
  - state IDLE; grant 0; busy 0; s_tready 0; m_tvalid 0; m_tlast 0; m_tdata/m_tkeep 0.
  - pkt_count 0; trunc_err 0; beat_cnt 0; last_grant = NSRC-1, so source 0 has first priority.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - req = s_tvalid & en_mask.
  - If req is nonzero, the winner is the first set bit of req searching circularly from last_grant+1. On the next clock edge: grant = onehot(winner), busy = 1, beat_cnt = 0, state GRANT.
  - All s_tready and m_tvalid are 0 in IDLE, giving a 1-cycle arbitration bubble per packet.
  - If req is 0, stay in IDLE.
- GRANT, owner g:
  - Combinational, zero-latency mux: m_tdata/m_tkeep/m_tvalid = s_tdata/s_tkeep/s_tvalid[g]; s_tready[g] = m_tready; every other s_tready is 0.
  - m_tlast = s_tlast[g] | (beat_cnt == MAX_BEATS-1).
  - Handshake = m_tvalid & m_tready; beat_cnt increments on each handshake.
  - On a handshake with m_tlast=1:
    - pkt_count increments; last_grant = g; grant = 0; busy = 0; state IDLE.
    - If s_tlast[g] was 0 (forced truncation), set trunc_err[g]. The source is not notified, and its remaining beats form a new packet at its next grant.
  - m_tvalid/m_tdata follow the source; the arbiter adds no buffering. AXI stability is the source's responsibility. The arbiter never drops a beat and never deasserts a grant mid-packet.
- en_mask changes mid-packet do not affect the current packet; the mask is used only at the next arbitration.
- Fairness: with all NSRC sources continuously requesting, grants rotate 0,1,..,NSRC-1,0,...
- A single requester is regranted every packet, with a bubble cycle between packets.
- trunc_err: a set and err_clear in the same cycle leaves the bit set (set wins); bits not being set are cleared.
- pkt_count and trunc_err are registered; updates are visible the cycle after the tlast handshake.

Test Plan:
- Reset, then source 0 only, 4-beat packet with tlast on beat 4, m_tready=1 → grant=0001 one cycle after tvalid; 4 output beats with identical data; m_tlast on beat 4; pkt_count=1; grant returns to 0 the next cycle.
- Sources 0-3 all requesting continuously, 2-beat packets, 8 packets → grant order 0,1,2,3,0,1,2,3; pkt_count=8; exactly 1 idle cycle between packets.
- Source 2 active, m_tready toggled 1,0,1,0 per cycle through a 3-beat packet → no beats lost or duplicated; s_tready[2] mirrors m_tready; s_tready of other sources stays 0.
- MAX_BEATS=8, source 1 sends 12 beats with no tlast → output packet 1 is 8 beats with forced m_tlast on beat 8 and trunc_err[1]=1; the remaining 4 beats go out as a new packet on the next grant; err_clear pulse → trunc_err=0.
- en_mask=1011 with sources 2 and 3 requesting → source 3 is granted, source 2 is never granted; clearing en_mask[3] mid-packet still completes that packet.
- areset asserted on beat 2 of a 5-beat packet → m_tvalid, s_tready, grant and busy go to 0 immediately; pkt_count=0; after release, source 0 wins first arbitration.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// ============================================================================
//  Module   : axis_rr_arbiter_if
//  Brief    : AXI-stream bundle for the packet round-robin arbiter: NSRC
//             packed source streams on the s_* side, one merged stream to
//             the DMA on the m_* side.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface axis_rr_arbiter_if #(
  parameter int NSRC = 4,
  parameter int DW   = 32
);
  // Source side: source i occupies slice [i*DW +: DW] / [i*DW/8 +: DW/8]
  logic [NSRC*DW-1:0]   s_tdata;
  logic [NSRC*DW/8-1:0] s_tkeep;
  logic [NSRC-1:0]      s_tlast;
  logic [NSRC-1:0]      s_tvalid;
  logic [NSRC-1:0]      s_tready;

  // DMA side
  logic [DW-1:0]        m_tdata;
  logic [DW/8-1:0]      m_tkeep;
  logic                 m_tlast;
  logic                 m_tvalid;
  logic                 m_tready;

  // Environment view: drives the sources and the DMA ready
  modport master (
    output s_tdata, s_tkeep, s_tlast, s_tvalid,
    input  s_tready,
    input  m_tdata, m_tkeep, m_tlast, m_tvalid,
    output m_tready
  );

  // Arbiter view: consumes the sources, drives the merged stream
  modport slave (
    input  s_tdata, s_tkeep, s_tlast, s_tvalid,
    output s_tready,
    output m_tdata, m_tkeep, m_tlast, m_tvalid,
    input  m_tready
  );
endinterface

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
// ============================================================================
//  Module   : axis_rr_arbiter
//  Brief    : Packet-level round-robin arbiter sharing one AXI-stream sink
//             between NSRC sources. A grant is held for a whole packet and
//             packets are cut at MAX_BEATS beats (forced tlast) so a source
//             that never ends its packet cannot stall the sink.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_rr_arbiter #(
  parameter int NSRC      = 4,
  parameter int DW        = 32,
  parameter int MAX_BEATS = 4096
) (
  input  logic                clk,
  input  logic                areset,
  input  logic [NSRC-1:0]     en_mask,
  input  logic                err_clear,
  axis_rr_arbiter_if.slave    bus,
  output logic [NSRC-1:0]     grant,
  output logic                busy,
  output logic [31:0]         pkt_count,
  output logic [NSRC-1:0]     trunc_err
);

  localparam int c_IW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int c_BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int c_KW = DW / 8;
  localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(MAX_BEATS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_q;
  logic [NSRC-1:0]     grant_q;
  logic                busy_q;
  logic [c_IW-1:0]     owner_q;
  logic [c_IW-1:0]     last_q;
  logic [c_BW-1:0]     beat_q;
  logic [31:0]         pkt_q;
  logic [NSRC-1:0]     trunc_q;

  logic [NSRC-1:0]     req;
  logic                win_vld;
  logic [c_IW-1:0]     win_idx;
  logic [NSRC-1:0]     win_onehot;
  logic                src_valid;
  logic                src_last;
  logic                out_last;
  logic                hs;
  logic [NSRC-1:0]     trunc_set;
  logic [NSRC-1:0]     trunc_err_d;

  assign req = bus.s_tvalid & en_mask;

  // Circular priority search starting just after the previous owner
  always_comb begin
    int idx;
    idx        = 0;
    win_vld    = 1'b0;
    win_idx    = last_q;
    win_onehot = '0;
    for (int k = 1; k <= NSRC; k++) begin
      idx = (int'(last_q) + k) % NSRC;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = c_IW'(idx);
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  // Zero-latency mux from the granted source; grant_q is all-zero in IDLE,
  // which also forces every output (and every s_tready) low there
  always_comb begin
    bus.m_tdata  = '0;
    bus.m_tkeep  = '0;
    bus.s_tready = '0;
    src_valid    = 1'b0;
    src_last     = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant_q[i]) begin
        bus.m_tdata     = bus.s_tdata[i*DW +: DW];
        bus.m_tkeep     = bus.s_tkeep[i*c_KW +: c_KW];
        src_valid       = bus.s_tvalid[i];
        src_last        = bus.s_tlast[i];
        bus.s_tready[i] = bus.m_tready;
      end
    end
  end

  // End of packet: the source's own tlast or the beat-count ceiling
  assign out_last     = busy_q & (src_last | (beat_q == c_LAST_BEAT));
  assign bus.m_tlast  = out_last;
  assign bus.m_tvalid = src_valid;
  assign hs           = src_valid & bus.m_tready;

  // A forced end of packet flags the owner; a new flag beats a clear
  assign trunc_set   = (hs && out_last && !src_last) ? grant_q : '0;
  assign trunc_err_d = (err_clear ? '0 : trunc_q) | trunc_set;

  // Arbitration FSM with beat counter, packet counter and sticky errors
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      last_q  <= c_IW'(NSRC - 1);
      beat_q  <= '0;
      pkt_q   <= '0;
      trunc_q <= '0;
    end else begin
      trunc_q <= trunc_err_d;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q <= GRANT;
            grant_q <= win_onehot;
            owner_q <= win_idx;
            busy_q  <= 1'b1;
            beat_q  <= '0;
          end
        end
        GRANT: begin
          if (hs) begin
            beat_q <= beat_q + 1'b1;
            if (out_last) begin
              pkt_q   <= pkt_q + 32'd1;
              last_q  <= owner_q;
              grant_q <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign pkt_count = pkt_q;
  assign trunc_err = trunc_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
// ============================================================================
//  Module   : tb_axis_rr_arbiter
//  Brief    : Self-checking bench for axis_rr_arbiter (NSRC=4, DW=32,
//             MAX_BEATS=8): directed scenarios followed by randomized
//             traffic, all compared cycle by cycle against a packet-level
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axis_rr_arbiter;

  localparam int NSRC = 4;
  localparam int DW   = 32;
  localparam int KW   = DW / 8;
  localparam int MAXB = 8;

  logic            clk = 1'b0;
  logic            areset = 1'b0;
  logic [NSRC-1:0] en_mask;
  logic            err_clear;
  logic [NSRC-1:0] grant;
  logic            busy;
  logic [31:0]     pkt_count;
  logic [NSRC-1:0] trunc_err;

  always #5 clk = ~clk;

  axis_rr_arbiter_if #(.NSRC(NSRC), .DW(DW)) bus ();

  axis_rr_arbiter #(.NSRC(NSRC), .DW(DW), .MAX_BEATS(MAXB)) dut (
    .clk       (clk),
    .areset    (areset),
    .en_mask   (en_mask),
    .err_clear (err_clear),
    .bus       (bus),
    .grant     (grant),
    .busy      (busy),
    .pkt_count (pkt_count),
    .trunc_err (trunc_err)
  );

  int errors = 0;
  int checks = 0;

  // Source emulation: each source has a list of packet lengths to send
  int              pkts[NSRC][$];
  int              rem[NSRC];
  bit              hold[NSRC];
  logic [DW-1:0]   cur_data[NSRC];
  logic [KW-1:0]   cur_keep[NSRC];
  bit              cur_last[NSRC];
  int unsigned     seq[NSRC];
  int unsigned     out_seq[NSRC];
  bit              gapless;

  // Reference model: owner (-1 = idle), previous owner, beats of current packet
  int              own;
  int              last_g;
  int              beats;
  logic [31:0]     m_pkt;
  logic [NSRC-1:0] m_terr;

  // Observations of the DUT used by directed scenarios
  int              obs_grants[$];
  logic [NSRC-1:0] prev_grant;
  int              obs_hs;
  int              idle_req;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_idle();
    bit r;
    r = (own < 0);
    for (int i = 0; i < NSRC; i++)
      if (hold[i] || rem[i] != 0 || pkts[i].size() != 0) r = 0;
    return r;
  endfunction

  // Present a new beat on any source that has data and is not holding one
  task automatic drive_sources();
    for (int i = 0; i < NSRC; i++) begin
      if (!hold[i]) begin
        if (rem[i] == 0 && pkts[i].size() > 0) rem[i] = pkts[i].pop_front();
        if (rem[i] > 0 && (gapless || $urandom_range(3) != 0)) begin
          cur_data[i] = {8'(i), 24'(seq[i])};
          cur_keep[i] = KW'($urandom_range(15)) | KW'(1);
          cur_last[i] = (rem[i] == 1);
          rem[i]--;
          seq[i]++;
          hold[i] = 1;
        end
      end
      bus.s_tdata[i*DW +: DW] = cur_data[i];
      bus.s_tkeep[i*KW +: KW] = cur_keep[i];
      bus.s_tlast[i]          = cur_last[i];
      bus.s_tvalid[i]         = hold[i];
    end
  endtask

  // Compare DUT outputs to the model, then advance the model by one clock
  task automatic observe_and_model();
    logic [NSRC-1:0] eg, erdy, req, nterr;
    bit ev, el;
    eg = '0;
    if (own >= 0) eg[own] = 1'b1;
    ev   = (own >= 0) && hold[own];
    el   = ev && (cur_last[own] || beats == MAXB - 1);
    erdy = bus.m_tready ? eg : '0;

    check("grant", grant, eg);
    check("busy", busy, own >= 0);
    check("pkt_count", pkt_count, m_pkt);
    check("trunc_err", trunc_err, m_terr);
    check("m_tvalid", bus.m_tvalid, ev);
    check("s_tready", bus.s_tready, erdy);
    if (ev) begin
      check("m_tdata", bus.m_tdata, cur_data[own]);
      check("m_tkeep", bus.m_tkeep, cur_keep[own]);
      check("m_tlast", bus.m_tlast, el);
    end else if (own < 0) begin
      check("idle_outputs", {bus.m_tdata, bus.m_tkeep, bus.m_tlast}, '0);
    end

    if (grant != '0 && prev_grant == '0)
      for (int i = 0; i < NSRC; i++) if (grant[i]) obs_grants.push_back(i);
    prev_grant = grant;
    if (bus.m_tvalid === 1'b1 && bus.m_tready) obs_hs++;
    for (int i = 0; i < NSRC; i++) req[i] = hold[i] & en_mask[i];
    if (grant == '0 && req != '0) idle_req++;

    nterr = err_clear ? '0 : m_terr;
    if (own < 0) begin
      for (int k = 1; k <= NSRC; k++) begin
        int idx;
        idx = (last_g + k) % NSRC;
        if (own < 0 && req[idx]) begin
          own   = idx;
          beats = 0;
        end
      end
    end else if (ev && bus.m_tready) begin
      check("beat_order", bus.m_tdata, {8'(own), 24'(out_seq[own])});
      out_seq[own]++;
      hold[own] = 0;
      beats++;
      if (el) begin
        m_pkt++;
        if (!cur_last[own]) nterr[own] = 1'b1;
        last_g = own;
        own    = -1;
      end
    end
    m_terr = nterr;
  endtask

  task automatic step();
    drive_sources();
    @(negedge clk);
    observe_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    step();
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    check("drain_done", all_idle(), 1);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock
  task automatic apply_reset();
    areset = 1'b1;
    #1;
    check("rst_grant", grant, '0);
    check("rst_busy", busy, 0);
    check("rst_s_tready", bus.s_tready, '0);
    check("rst_m_tvalid", bus.m_tvalid, 0);
    check("rst_m_out", {bus.m_tdata, bus.m_tkeep, bus.m_tlast}, '0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_trunc_err", trunc_err, '0);
    for (int i = 0; i < NSRC; i++) begin
      pkts[i].delete();
      rem[i] = 0; hold[i] = 0; cur_last[i] = 0;
      cur_data[i] = '0; cur_keep[i] = '0;
      seq[i] = 0; out_seq[i] = 0;
    end
    own = -1; last_g = NSRC - 1; beats = 0; m_pkt = '0; m_terr = '0;
    prev_grant = '0;
    bus.s_tvalid = '0; bus.s_tlast = '0; bus.s_tdata = '0; bus.s_tkeep = '0;
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_grants.delete();
    obs_hs   = 0;
    idle_req = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    en_mask      = '1;
    err_clear    = 1'b0;
    bus.m_tready = 1'b1;
    gapless      = 1;
    #3;
    apply_reset();

    // Single source, 4-beat packet
    clear_obs();
    pkts[0].push_back(4);
    step();
    check("t1_grant", grant, 4'b0001);
    repeat (4) step();
    check("t1_beats", obs_hs, 4);
    check("t1_pkt", pkt_count, 1);
    check("t1_grant_released", grant, '0);

    // All four sources continuously requesting, 2-beat packets
    apply_reset();
    clear_obs();
    for (int i = 0; i < NSRC; i++) begin
      pkts[i].push_back(2);
      pkts[i].push_back(2);
    end
    run_until_idle(200);
    check("t2_grant_count", obs_grants.size(), 8);
    for (int k = 0; k < obs_grants.size(); k++)
      check($sformatf("t2_order%0d", k), obs_grants[k], k % NSRC);
    check("t2_pkt", pkt_count, 8);
    check("t2_bubbles", idle_req, 8);

    // Back-pressure toggling every cycle on source 2
    clear_obs();
    pkts[2].push_back(3);
    for (int c = 0; c < 30 && !(c > 0 && all_idle()); c++) begin
      bus.m_tready = (c % 2 == 0);
      step();
    end
    bus.m_tready = 1'b1;
    check("t3_done", all_idle(), 1);
    check("t3_beats", obs_hs, 3);
    check("t3_pkt", pkt_count, 9);

    // 12 beats with no tlast until the last beat: cut at 8, rest re-granted
    clear_obs();
    pkts[1].push_back(12);
    run_until_idle(100);
    check("t4_grant_count", obs_grants.size(), 2);
    for (int k = 0; k < obs_grants.size(); k++)
      check($sformatf("t4_owner%0d", k), obs_grants[k], 1);
    check("t4_beats", obs_hs, 12);
    check("t4_pkt", pkt_count, 11);
    check("t4_trunc", trunc_err, 4'b0010);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("t4_trunc_cleared", trunc_err, '0);

    // Masked source never wins; mask change mid-packet is ignored
    clear_obs();
    en_mask = 4'b1011;
    pkts[2].push_back(2);
    pkts[3].push_back(4);
    step();
    check("t5_grant", grant, 4'b1000);
    step();
    en_mask = 4'b0011;
    for (int c = 0; c < 20 && own >= 0; c++) step();
    check("t5_pkt", pkt_count, 12);
    repeat (4) step();
    check("t5_grant_count", obs_grants.size(), 1);
    if (obs_grants.size() > 0) check("t5_owner", obs_grants[0], 3);
    check("t5_idle", grant, '0);
    en_mask = 4'b1111;
    run_until_idle(50);
    check("t5_drain_pkt", pkt_count, 13);

    // Reset in the middle of a 5-beat packet
    pkts[0].push_back(5);
    step();
    step();
    drive_sources();
    #1;
    check("t6_pre_reset_valid", bus.m_tvalid, 1);
    apply_reset();
    clear_obs();
    for (int i = 0; i < NSRC; i++) pkts[i].push_back(2);
    run_until_idle(100);
    check("t6_grant_count", obs_grants.size(), 4);
    if (obs_grants.size() > 0) check("t6_first_owner", obs_grants[0], 0);
    check("t6_pkt", pkt_count, 4);

    // Randomized traffic, back-pressure, masking and error clears
    gapless = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NSRC; i++)
        if (pkts[i].size() == 0 && $urandom_range(7) == 0)
          pkts[i].push_back(int'($urandom_range(1, 12)));
      bus.m_tready = ($urandom_range(3) != 0);
      if ($urandom_range(19) == 0) en_mask = NSRC'($urandom_range(15));
      err_clear = ($urandom_range(29) == 0);
      step();
    end
    err_clear    = 1'b0;
    en_mask      = '1;
    bus.m_tready = 1'b1;
    gapless      = 1;
    run_until_idle(3000);
    check("rand_pkt_total", pkt_count, m_pkt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
